// File: rtl/memoria_banked.sv
// Byte-interleaved data memory: NBYTES single-byte banks, any-alignment loads/stores,
// valid/ready request port and a one-deep registered, back-pressurable load response.
module memoria_banked #(
    parameter int unsigned NBYTES = 4,
    parameter int unsigned ADDR_W = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_wr,
    input  logic [31:0]           i_req_addr,
    input  logic [1:0]            i_req_size,
    input  logic                  i_req_unsigned,
    input  logic [8*NBYTES-1:0]   i_req_wdata,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [8*NBYTES-1:0]   o_rsp_rdata,
    output logic                  o_rsp_err
);
    localparam int unsigned LOG2  = (NBYTES > 1) ? $clog2(NBYTES) : 0;
    localparam int unsigned OFF_W = (LOG2 > 0) ? LOG2 : 1;
    localparam int unsigned ROW_W = ADDR_W - LOG2;
    localparam int unsigned ROWS  = 1 << ROW_W;
    localparam int unsigned DW    = 8 * NBYTES;

    typedef enum logic {S_IDLE, S_RESP} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [7:0]         r_mem [NBYTES][ROWS];
    logic [DW-1:0]      r_rdata;
    logic               r_err;

    logic [ADDR_W-1:0]  w_addr;
    logic [OFF_W-1:0]   w_off;
    logic [ROW_W-1:0]   w_row_base;
    logic [31:0]        w_size_bytes;
    logic               w_legal;
    logic               w_accept;
    logic               w_load_acc;
    logic               w_wr_en;
    logic [NBYTES-1:0]  w_touch;
    logic [OFF_W-1:0]   w_diff  [NBYTES];
    logic [ROW_W-1:0]   w_row   [NBYTES];
    logic [7:0]         w_wbyte [NBYTES];
    logic [7:0]         w_rbyte [NBYTES];
    logic [DW-1:0]      w_load;
    logic               w_sign;

    generate
        if (ADDR_W < 32) begin : g_addr_hi
            logic w_unused_addr;
            assign w_unused_addr = ^i_req_addr[31:ADDR_W];
        end
    endgenerate

    assign w_addr       = i_req_addr[ADDR_W-1:0];
    assign w_off        = OFF_W'(w_addr & ADDR_W'(NBYTES - 1));
    assign w_row_base   = ROW_W'(w_addr >> LOG2);
    assign w_size_bytes = 32'(1) << i_req_size;
    assign w_legal      = (32'(i_req_size) <= LOG2);
    assign w_accept     = i_req_valid && o_req_ready;
    assign w_load_acc   = w_accept && !i_req_wr;
    assign w_wr_en      = w_accept && i_req_wr && w_legal && !i_rst;

    // Per-lane byte position within the access, row (carrying into the next row) and data
    always_comb begin
        for (int unsigned l = 0; l < NBYTES; l++) begin
            w_diff[l]  = OFF_W'((32'(l) - 32'(w_off)) & 32'(NBYTES - 1));
            w_touch[l] = (32'(w_diff[l]) < w_size_bytes);
            w_row[l]   = w_row_base + ROW_W'(32'(l) < 32'(w_off));
            w_wbyte[l] = i_req_wdata[8*w_diff[l] +: 8];
            w_rbyte[l] = r_mem[l][w_row[l]];
        end
    end

    // Rotate lanes back to access order and extend above the access size
    always_comb begin
        w_load = '0;
        w_sign = w_rbyte[OFF_W'((32'(w_off) + w_size_bytes - 32'(1)) & 32'(NBYTES - 1))][7]
                 && !i_req_unsigned;
        for (int unsigned k = 0; k < NBYTES; k++) begin
            if (32'(k) < w_size_bytes) begin
                w_load[8*k +: 8] = w_rbyte[OFF_W'((32'(w_off) + 32'(k)) & 32'(NBYTES - 1))];
            end else begin
                w_load[8*k +: 8] = {8{w_sign}};
            end
        end
        if (!w_legal) begin
            w_load = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            for (int unsigned l = 0; l < NBYTES; l++) begin
                if (w_touch[l]) begin
                    r_mem[l][w_row[l]] <= w_wbyte[l];
                end
            end
        end
    end

    // Load result captured at accept so a stalled response stays stable
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_load_acc) begin
            r_rdata <= w_load;
            r_err   <= !w_legal;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_load_acc) w_state_nxt = S_RESP;
            S_RESP: if (i_rsp_ready && !w_load_acc) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_rsp_valid = (r_state == S_RESP);
        o_req_ready = !i_rst && (!o_rsp_valid || i_rsp_ready);
        o_rsp_rdata = o_rsp_valid ? r_rdata : '0;
        o_rsp_err   = o_rsp_valid && r_err;
    end

endmodule

// File: tb/tb_memoria_banked.sv
// Directed bench for memoria_banked: byte-array reference model, expected-response queue.
module tb_memoria_banked;
    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic        i_req_wr = 1'b0;
    logic [31:0] i_req_addr = '0;
    logic [1:0]  i_req_size = '0;
    logic        i_req_unsigned = 1'b0;
    logic [31:0] i_req_wdata = '0;
    logic        o_rsp_valid;
    logic        i_rsp_ready = 1'b1;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_err;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } rsp_t;

    rsp_t        exp_q[$];
    rsp_t        cur;
    logic [7:0]  mdl [0:65535];
    int          n_checks = 0;
    int          n_err = 0;

    memoria_banked #(.NBYTES(4), .ADDR_W(16)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_wr(i_req_wr), .i_req_addr(i_req_addr), .i_req_size(i_req_size),
        .i_req_unsigned(i_req_unsigned), .i_req_wdata(i_req_wdata),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic rsp_t model_load(input logic [31:0] a, input logic [1:0] sz,
                                        input logic uns);
        rsp_t r;
        int   s;
        logic sgn;
        s = 1 << sz;
        r = '0;
        if (s > 4) begin
            r.err = 1'b1;
            return r;
        end
        for (int k = 0; k < s; k++) r.data[8*k +: 8] = mdl[16'(a + 32'(k))];
        sgn = r.data[8*s-1] & ~uns;
        for (int k = s; k < 4; k++) r.data[8*k +: 8] = {8{sgn}};
        return r;
    endfunction

    // Present a request and hold it until the edge that accepts it
    task automatic send(input logic wr, input logic [31:0] a, input logic [1:0] sz,
                        input logic uns, input logic [31:0] wd);
        int n;
        n = 0;
        i_req_wr = wr; i_req_addr = a; i_req_size = sz;
        i_req_unsigned = uns; i_req_wdata = wd; i_req_valid = 1'b1;
        while (!o_req_ready && n < 20) begin
            @(posedge i_clk); #1;
            n++;
        end
        chk("accept_timeout", 33'(n < 20), 33'(1));
        @(posedge i_clk); #1;
        i_req_valid = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
        if ((1 << sz) <= 4) begin
            for (int k = 0; k < (1 << sz); k++) mdl[16'(a + 32'(k))] = wd[8*k +: 8];
        end
        send(1'b1, a, sz, 1'b0, wd);
    endtask

    task automatic load(input string tag, input logic [31:0] a, input logic [1:0] sz,
                        input logic uns);
        exp_q.push_back(model_load(a, sz, uns));
        send(1'b0, a, sz, uns, 32'h0);
        chk({tag, "_valid"}, 33'(o_rsp_valid), 33'(1));
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            chk({tag, "_data"}, {o_rsp_err, o_rsp_rdata}, {cur.err, cur.data});
        end
    endtask

    initial begin
        #1;
        chk("rst_ready", 33'(o_req_ready), 33'(0));
        chk("rst_rsp", {o_rsp_err, o_rsp_rdata}, 33'(0));
        repeat (2) @(posedge i_clk);
        #1 i_rst = 1'b0;
        chk("idle_valid", 33'(o_rsp_valid), 33'(0));

        store(32'h100, 2'd2, 32'hDEADBEEF);
        load("word_100", 32'h100, 2'd2, 1'b0);
        load("sbyte_103", 32'h103, 2'd0, 1'b0);
        load("ubyte_103", 32'h103, 2'd0, 1'b1);

        store(32'h1FD, 2'd0, 32'h5A);
        store(32'h202, 2'd0, 32'hA5);
        store(32'h1FE, 2'd2, 32'h11223344);
        load("mis_word", 32'h1FE, 2'd2, 1'b0);
        for (int i = 0; i < 6; i++) load("mis_byte", 32'h1FD + 32'(i), 2'd0, 1'b1);

        store(32'h40, 2'd2, 32'hFFFFFFFF);
        store(32'h41, 2'd1, 32'h8001);
        load("part_word", 32'h40, 2'd2, 1'b0);
        load("shalf_41", 32'h41, 2'd1, 1'b0);
        load("uhalf_41", 32'h41, 2'd1, 1'b1);

        store(32'hFFFF, 2'd1, 32'hABCD);
        load("wrap_top", 32'hFFFF, 2'd0, 1'b1);
        load("wrap_zero", 32'h0, 2'd0, 1'b1);
        load("wrap_half", 32'hFFFF, 2'd1, 1'b0);

        load("illegal_ld", 32'h100, 2'd3, 1'b0);
        store(32'h100, 2'd3, 32'h0);
        load("illegal_st", 32'h100, 2'd2, 1'b0);

        // Back-pressure: first response stalls, second load waits, then both flow
        i_rsp_ready = 1'b0;
        exp_q.push_back(model_load(32'h100, 2'd2, 1'b0));
        send(1'b0, 32'h100, 2'd2, 1'b0, 32'h0);
        exp_q.push_back(model_load(32'h40, 2'd2, 1'b0));
        i_req_wr = 1'b0; i_req_addr = 32'h40; i_req_size = 2'd2;
        i_req_unsigned = 1'b0; i_req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_ready", 33'(o_req_ready), 33'(0));
            chk("bp_valid", 33'(o_rsp_valid), 33'(1));
            chk("bp_data", {o_rsp_err, o_rsp_rdata}, {exp_q[0].err, exp_q[0].data});
            @(posedge i_clk); #1;
        end
        i_rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", 33'(o_req_ready), 33'(1));
        @(posedge i_clk); #1;
        i_req_valid = 1'b0;
        void'(exp_q.pop_front());
        chk("bp_next_valid", 33'(o_rsp_valid), 33'(1));
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            chk("bp_next_data", {o_rsp_err, o_rsp_rdata}, {cur.err, cur.data});
        end
        @(posedge i_clk); #1;
        chk("bp_drain", 33'(o_rsp_valid), 33'(0));

        // Asynchronous reset with a stalled response and a store presented
        i_rsp_ready = 1'b0;
        exp_q.push_back(model_load(32'h40, 2'd2, 1'b0));
        send(1'b0, 32'h40, 2'd2, 1'b0, 32'h0);
        chk("pre_rst_valid", 33'(o_rsp_valid), 33'(1));
        i_req_wr = 1'b1; i_req_addr = 32'h100; i_req_size = 2'd2;
        i_req_wdata = 32'h0; i_req_valid = 1'b1;
        #2 i_rst = 1'b1;
        #1;
        chk("async_valid", 33'(o_rsp_valid), 33'(0));
        chk("async_rsp", {o_rsp_err, o_rsp_rdata}, 33'(0));
        chk("async_ready", 33'(o_req_ready), 33'(0));
        exp_q.delete();
        i_rsp_ready = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        i_req_valid = 1'b0;
        load("post_rst_100", 32'h100, 2'd2, 1'b0);
        load("post_rst_40", 32'h40, 2'd2, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule
